// File: rtl/lfsr_seq_pkg.sv
// Shared types and helpers for the LFSR sequencer: FSM state encoding,
// default feedback taps and the single-step Fibonacci LFSR function.
package lfsr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [3:0] DEFAULT_TAPS = 4'b1001;

  // Widest LFSR the step function supports; narrower users zero-extend.
  localparam int LFSR_MAX_W = 32;

  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with load and step controls; resets to 1 so the
// register never starts in the all-zero lock-up state.
import lfsr_seq_pkg::*;

module lfsr_core #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   TAPS = W'(DEFAULT_TAPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [LFSR_MAX_W-1:0] next_full;
  logic                  unused_next;

  assign next_full   = lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS));
  assign unused_next = ^next_full;

  // Load wins over step; the controller never requests both at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= {{(W-1){1'b0}}, 1'b1};
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= next_full[W-1:0];
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR sequencer: accepts (seed, len), streams len words, pulses done.
// Define LFSR_SEQ_ZERO_SEED_ERR_EN to reject zero seeds with an err pulse.
import lfsr_seq_pkg::*;

module lfsr_seq_ctrl #(
  parameter int           W     = 4,
  parameter logic [W-1:0] TAPS  = W'(DEFAULT_TAPS),
  parameter int           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_seed,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     lfsr_state,
  output logic [1:0]       dbg_state
`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
  ,
  output logic             err
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_valid is held with stable out_data until accepted or aborted.

  seq_state_t       state;
  logic [CNT_W-1:0] remaining;
  logic             seed_zero;
  logic             accept;
  logic             exec;
  logic             beat;
  logic [W-1:0]     load_val;

  assign seed_zero = (cmd_seed == '0);
  assign accept    = (state == IDLE) && cmd_valid;
  assign beat      = (state == RUN) && out_ready;
  assign load_val  = seed_zero ? {{(W-1){1'b0}}, 1'b1} : cmd_seed;
  assign out_data  = lfsr_state;
  assign dbg_state = state;

`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
  assign exec = accept && !seed_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= accept && seed_zero;
    end
  end
`else
  assign exec = accept;
`endif

  lfsr_core #(
    .W    (W),
    .TAPS (TAPS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (exec),
    .load_val (load_val),
    .step     (beat),
    .state    (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exec) begin
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len != '0) begin
              state     <= RUN;
              out_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // A beat taken in the abort cycle still counts.
          if (out_ready && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (out_ready && remaining == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed cases plus randomized
// commands, backpressure and aborts against an arithmetic reference model.
module tb_lfsr_seq_ctrl;

  localparam int           W     = 4;
  localparam int           CNT_W = 8;
  localparam logic [3:0]   TAPS  = 4'b1001;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_seed;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;
  logic             done;
  logic [W-1:0]     lfsr_state;
  logic [1:0]       dbg_state;
`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
  logic             err;
`endif

  int tests  = 0;
  int failed = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  seen;

  lfsr_seq_ctrl #(.W(W), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_seed   (cmd_seed),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .lfsr_state (lfsr_state),
    .dbg_state  (dbg_state)
`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
    ,
    .err        (err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift left by one, feed back the parity of the tapped bits.
  function automatic logic [3:0] model_next(input logic [3:0] s);
    int v;
    v = (int'(s) * 2) % 16 + ($countones(s & TAPS) % 2);
    return 4'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one command and consume its beats. Called and returns at a negedge.
  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_cmd(input logic [3:0] seed, input int len, input int mode,
                         input int abort_at, input bit abort_rdy,
                         output logic [15:0] seen_o);
    logic [3:0] m;
    logic [3:0] s;
    logic [3:0] prev_data;
    logic       rdy;
    bit         prev_stall;
    bit         finished;
    bit         aborted;
    int         acc;
    int         cyc;
    int         last_cyc;
    seen_o = '0;
    m = (seed == 4'd0) ? 4'd1 : seed;
    s = m;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(s);
      s = model_next(s);
    end
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = CNT_W'(len);
    @(negedge clk);
    cmd_valid  = 1'b0;
    acc        = 0;
    cyc        = 0;
    last_cyc   = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    finished   = 1'b0;
    aborted    = 1'b0;
    while (!finished && cyc < 400) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (done) begin
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        check("done_no_valid", 32'(out_valid), 32'd0);
        check("beats_at_done", 32'(acc), 32'(len));
        check("done_latency", 32'(cyc - last_cyc), 32'd1);
        check("done_lfsr", 32'(lfsr_state), 32'(m));
        finished = 1'b1;
      end else begin
        check("run_valid", 32'(out_valid), 32'd1);
        check("run_busy_ready", 32'({busy, cmd_ready}), 32'b10);
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = (cyc % 3 == 0);
        else                rdy = 1'($urandom_range(0, 1));
        if (acc == abort_at) begin
          abort = 1'b1;
          rdy   = abort_rdy;
        end
        out_ready = rdy;
        cmd_valid = (mode == 2 && !abort) ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_seed  = 4'($urandom);
        cmd_len   = CNT_W'($urandom);
        if (rdy) begin
          if (exp_q.size() == 0) check("beat_overrun", 32'(acc + 1), 32'(len));
          else                   check("beat_data", 32'(out_data), 32'(exp_q.pop_front()));
          seen_o[out_data] = 1'b1;
          m        = model_next(m);
          acc++;
          last_cyc = cyc;
        end
        prev_stall = !rdy;
        prev_data  = out_data;
        if (abort) begin
          @(negedge clk);
          abort     = 1'b0;
          out_ready = 1'b0;
          cmd_valid = 1'b0;
          check("abort_valid", 32'(out_valid), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
          check("abort_lfsr", 32'(lfsr_state), 32'(m));
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
          end
          finished = 1'b1;
          aborted  = 1'b1;
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("cmd_completed", 32'(finished), 32'd1);
    if (!aborted) begin
      @(negedge clk);
      check("post_done_pulse", 32'(done), 32'd0);
      check("post_done_idle", 32'({busy, cmd_ready}), 32'b01);
      check("post_done_lfsr", 32'(lfsr_state), 32'(m));
    end
  endtask

  initial begin
    int len;
    int ab;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_seed  = '0;
    cmd_len   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lfsr", 32'(lfsr_state), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic five-beat run, then same run under 1,0,0 backpressure.
    run_cmd(4'd1, 5, 0, -1, 1'b0, seen);
    check("t1_final_lfsr", 32'(lfsr_state), 32'hD);
    check("t1_beats_seen", 32'(seen), 32'h0000_C08A);
    run_cmd(4'd1, 5, 1, -1, 1'b0, seen);
    check("t2_final_lfsr", 32'(lfsr_state), 32'hD);

    // Full period.
    run_cmd(4'd1, 15, 0, -1, 1'b0, seen);
    check("t3_all_values", 32'(seen), 32'h0000_FFFE);
    check("t3_final_lfsr", 32'(lfsr_state), 32'h1);

    // Zero length.
    run_cmd(4'd5, 0, 0, -1, 1'b0, seen);
    check("t4_lfsr", 32'(lfsr_state), 32'h5);

    // Abort after two accepted beats.
    run_cmd(4'd1, 10, 0, 2, 1'b0, seen);
    check("t5_lfsr", 32'(lfsr_state), 32'h7);

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort", 32'({busy, cmd_ready}), 32'b01);

    // Zero seed.
`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
    cmd_valid = 1'b1;
    cmd_seed  = 4'd0;
    cmd_len   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("zs_err", 32'(err), 32'd1);
    check("zs_idle", 32'({busy, cmd_ready, out_valid, done}), 32'b0100);
    @(negedge clk);
    check("zs_err_pulse", 32'(err), 32'd0);
    check("zs_still_idle", 32'({busy, out_valid, done}), 32'b000);
`else
    run_cmd(4'd0, 3, 0, -1, 1'b0, seen);
    check("zs_beats", 32'(seen), 32'h0000_008A);
`endif

    // Reset mid-run.
    cmd_valid = 1'b1;
    cmd_seed  = 4'd9;
    cmd_len   = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", 32'({cmd_ready, out_valid, done, busy}), 32'b1000);
    check("mid_rst_lfsr", 32'(lfsr_state), 32'd1);
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_no_done", 32'({done, busy}), 32'b00);

    // Randomized commands, backpressure, busy-time commands and aborts.
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 20);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
`ifdef LFSR_SEQ_ZERO_SEED_ERR_EN
      run_cmd(4'($urandom_range(1, 15)), len, 2, ab, 1'($urandom_range(0, 1)), seen);
`else
      run_cmd(4'($urandom_range(0, 15)), len, 2, ab, 1'($urandom_range(0, 1)), seen);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
